argmax_l2: RTL and testbench

ARGMAX_L2 -- requirements
Module: argmax_l2

---
 rtl/argmax_l2_if.sv | 22 ++
 rtl/argmax_l2.sv | 142 ++++++++++++++
 tb/tb_argmax_l2.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/argmax_l2_if.sv
// Handshake and data bundle between an argmax_l2 classifier and its host.
// master: host side (drives start/data/ack); slave: classifier side.
interface argmax_l2_if;
    logic         start;
    logic [199:0] acc_in_packed;
    logic         ack;
    logic         busy;
    logic         done;
    logic [3:0]   class_idx;
    logic [19:0]  max_score;
    logic [20:0]  margin;

    modport master (
        output start, acc_in_packed, ack,
        input  busy, done, class_idx, max_score, margin
    );

    modport slave (
        input  start, acc_in_packed, ack,
        output busy, done, class_idx, max_score, margin
    );
endinterface

// File: rtl/argmax_l2.sv
// Sequential argmax over ten signed 20-bit accumulators, one lane per cycle.
// Reports winning index, winning score and margin to the runner-up.
// Build option: define ARGMAX_TIE_HIGH_EN to resolve ties toward the highest
// lane index; by default ties resolve toward the lowest index.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; last result held on the outputs
// SCAN    | walking lanes 0..9 of the snapshot, tracking best and second
// DONE    | result valid and frozen until ack
module argmax_l2 (
    input  logic        clk,
    input  logic        rst,
    argmax_l2_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic signed [19:0] SCORE_MIN = 20'sh80000;

    logic [1:0]          state_q,      state_d;
    logic [3:0]          lane_q,       lane_d;
    logic [199:0]        snap_q,       snap_d;
    logic signed [19:0]  best_q,       best_d;
    logic signed [19:0]  second_q,     second_d;
    logic [3:0]          best_idx_q,   best_idx_d;
    logic [3:0]          res_idx_q,    res_idx_d;
    logic [19:0]         res_max_q,    res_max_d;
    logic [20:0]         res_margin_q, res_margin_d;

    logic signed [19:0]  lane_arr [16];
    logic signed [19:0]  lane_val;
    logic                lane_wins;
    logic [20:0]         diff;

    // Split the snapshot into lanes; unused upper slots read as zero.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            lane_arr[i] = '0;
        end
        for (int i = 0; i < 10; i++) begin
            lane_arr[i] = snap_q[i*20 +: 20];
        end
        lane_val = lane_arr[lane_q];
`ifdef ARGMAX_TIE_HIGH_EN
        lane_wins = (lane_val >= best_q);
`else
        lane_wins = (lane_val > best_q);
`endif
    end

    // Next-state, scan datapath and result capture.
    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        snap_d       = snap_q;
        best_d       = best_q;
        second_d     = second_q;
        best_idx_d   = best_idx_q;
        res_idx_d    = res_idx_q;
        res_max_d    = res_max_q;
        res_margin_d = res_margin_q;
        diff         = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    snap_d  = bus.acc_in_packed;
                    lane_d  = 4'd0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (lane_q == 4'd0) begin
                    best_d     = lane_val;
                    best_idx_d = 4'd0;
                    second_d   = SCORE_MIN;
                end else if (lane_wins) begin
                    second_d   = best_q;
                    best_d     = lane_val;
                    best_idx_d = lane_q;
                end else if (lane_val > second_q) begin
                    second_d   = lane_val;
                end

                // Sign-extend both to 21 bits; the difference is always
                // non-negative and below 2^21, so it fits unsigned.
                diff = {best_d[19], best_d} - {second_d[19], second_d};

                if (lane_q == 4'd9) begin
                    state_d      = ST_DONE;
                    res_idx_d    = best_idx_d;
                    res_max_d    = best_d;
                    res_margin_d = diff;
                end else begin
                    lane_d = lane_q + 4'd1;
                end
            end
            ST_DONE: begin
                if (bus.ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any classification in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            lane_q       <= '0;
            snap_q       <= '0;
            best_q       <= '0;
            second_q     <= '0;
            best_idx_q   <= '0;
            res_idx_q    <= '0;
            res_max_q    <= '0;
            res_margin_q <= '0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            snap_q       <= snap_d;
            best_q       <= best_d;
            second_q     <= second_d;
            best_idx_q   <= best_idx_d;
            res_idx_q    <= res_idx_d;
            res_max_q    <= res_max_d;
            res_margin_q <= res_margin_d;
        end
    end

    assign bus.busy      = (state_q == ST_SCAN) || (state_q == ST_DONE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.class_idx = res_idx_q;
    assign bus.max_score = res_max_q;
    assign bus.margin    = res_margin_q;

endmodule

// File: tb/tb_argmax_l2.sv
// Directed bench for argmax_l2. Expected values are hand-computed; tie
// expectations follow ARGMAX_TIE_HIGH_EN when the bench is built with it.
module tb_argmax_l2;
    typedef int lanes_t [10];

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    argmax_l2_if bus ();

    argmax_l2 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [199:0] pack(input lanes_t v);
        logic [199:0] p;
        logic [31:0]  w;
        p = '0;
        for (int j = 0; j < 10; j++) begin
            w = v[j];
            p[j*20 +: 20] = w[19:0];
        end
        return p;
    endfunction

    task automatic chk_result(input string tag, input int ei, input int em, input int eg);
        logic [31:0] wi, wm, wg;
        wi = ei;
        wm = em;
        wg = eg;
        chk({tag, "_idx"},    {28'd0, bus.class_idx}, {28'd0, wi[3:0]});
        chk({tag, "_max"},    {12'd0, bus.max_score}, {12'd0, wm[19:0]});
        chk({tag, "_margin"}, {11'd0, bus.margin},    {11'd0, wg[20:0]});
    endtask

    // Present lanes with a one-cycle start, check done timing and result.
    task automatic run_case(input string tag, input lanes_t v,
                            input int ei, input int em, input int eg);
        bus.acc_in_packed = pack(v);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        repeat (9) tick();
        chk({tag, "_done_early"}, {31'd0, bus.done}, 32'd0);
        tick();
        chk({tag, "_done"}, {31'd0, bus.done}, 32'd1);
        chk_result(tag, ei, em, eg);
    endtask

    task automatic do_ack(input string tag, input int ei, input int em, input int eg);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk({tag, "_ack_done"}, {31'd0, bus.done}, 32'd0);
        chk({tag, "_ack_busy"}, {31'd0, bus.busy}, 32'd0);
        tick();
        chk_result({tag, "_held"}, ei, em, eg);
    endtask

    initial begin
        int tie_idx;
        int tie36_idx;
        int bad_cnt;

        n_cmp = 0;
        n_bad = 0;
`ifdef ARGMAX_TIE_HIGH_EN
        tie_idx   = 9;
        tie36_idx = 6;
`else
        tie_idx   = 0;
        tie36_idx = 3;
`endif
        rst = 1'b1;
        bus.start = 1'b0;
        bus.ack = 1'b0;
        bus.acc_in_packed = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk_result("rst", 0, 0, 0);

        // ack in IDLE must do nothing
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("idle_ack_busy", {31'd0, bus.busy}, 32'd0);

        run_case("basic", '{5, -3, 100, 7, 0, 0, 0, 0, 0, -1}, 2, 100, 93);
        do_ack("basic", 2, 100, 93);

        run_case("allmin", '{-524288, -524288, -524288, -524288, -524288,
                             -524288, -524288, -524288, -524288, -524288},
                 tie_idx, -524288, 0);
        do_ack("allmin", tie_idx, -524288, 0);

        run_case("extreme", '{-524288, -1, -1, -1, -1, -1, -1, -1, -1, 524287},
                 9, 524287, 524288);
        do_ack("extreme", 9, 524287, 524288);

        run_case("tie36", '{1, 2, 3, 50, 4, 5, 50, 6, 7, 8}, tie36_idx, 50, 0);
        do_ack("tie36", tie36_idx, 50, 0);

        run_case("neg", '{-10, -20, -5, -30, -7, -100, -6, -50, -9, -8}, 2, -5, 1);
        do_ack("neg", 2, -5, 1);

        // Snapshot isolation: new data and start during SCAN are ignored.
        bus.acc_in_packed = pack('{5, -3, 100, 7, 0, 0, 0, 0, 0, -1});
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (2) tick();
        bus.acc_in_packed = pack('{500, 1, 2, 3, 4, 5, 6, 7, 8, 9});
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (6) tick();
        chk("snap_done_early", {31'd0, bus.done}, 32'd0);
        tick();
        chk("snap_done", {31'd0, bus.done}, 32'd1);
        chk_result("snap", 2, 100, 93);
        do_ack("snap", 2, 100, 93);
        bad_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad_cnt++;
        end
        chk("snap_no_requeue", bad_cnt, 0);

        // Reset in the middle of SCAN clears everything.
        bus.acc_in_packed = pack('{5, -3, 100, 7, 0, 0, 0, 0, 0, -1});
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        bus.start = 1'b1;
        bus.ack = 1'b1;
        tick();
        rst = 1'b0;
        bus.start = 1'b0;
        bus.ack = 1'b0;
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_done", {31'd0, bus.done}, 32'd0);
        chk_result("midrst", 0, 0, 0);
        run_case("after_rst", '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10}, 9, 10, 1);

        // Hold DONE with ack low; start alone must not disturb it.
        for (int k = 0; k < 20; k++) begin
            bus.start = (k == 7);
            tick();
            chk("hold_done", {31'd0, bus.done}, 32'd1);
            chk_result("hold", 9, 10, 1);
        end
        bus.start = 1'b1;
        bus.ack = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.ack = 1'b0;
        chk("startack_busy", {31'd0, bus.busy}, 32'd0);
        chk("startack_done", {31'd0, bus.done}, 32'd0);
        bad_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) bad_cnt++;
        end
        chk("startack_no_scan", bad_cnt, 0);
        chk_result("startack_held", 9, 10, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
